// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the CPU and a
// DMA/loader requester. It serialises accesses (one in flight at a time), waits
// out the memory read latency and returns one ack pulse per access.
//
// Optional build macro: MEM_ARB_CPU_PRIORITY_EN
//   defined   -> fixed priority, the CPU wins every simultaneous request
//   undefined -> round-robin on simultaneous requests (CPU wins the first tie)
//
// Handshake: a requester raises req with we/addr/wdata stable and holds it until
// its ack pulse. It drops req in the cycle after the ack. Req still high in the
// IDLE cycle that follows DONE counts as a new request. Req changes made by the
// requester that does not own the current access are ignored until IDLE.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          grant_cpu, grant_dma;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  // Fixed priority: the CPU wins whenever it requests.
  always_comb begin
    grant_cpu = cpu_req;
    grant_dma = dma_req && !cpu_req;
  end
`else
  logic last_gnt_q, last_gnt_d;

  // Round-robin: on a tie the requester that was not granted last time wins.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (cpu_req && dma_req) begin
      grant_cpu = (last_gnt_q == OWN_DMA);
      grant_dma = (last_gnt_q == OWN_CPU);
    end else begin
      grant_cpu = cpu_req;
      grant_dma = dma_req;
    end
    last_gnt_d = last_gnt_q;
    if (state_q == S_IDLE && (grant_cpu || grant_dma)) begin
      last_gnt_d = grant_dma ? OWN_DMA : OWN_CPU;
    end
  end

  // Last-grant register; reset to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= OWN_DMA;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Next-state logic: grant and latch in IDLE, strobe in ISSUE, count in WAIT.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_dma) begin
          owner_d = grant_dma ? OWN_DMA : OWN_CPU;
          we_d    = grant_dma ? dma_we    : cpu_we;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      S_WAIT: begin
        // Count 0 marks the cycle where mem_rdata is valid (MEM_LAT after ISSUE).
        if (lat_cnt_q == 3'd0) begin
          state_d = S_DONE;
          if (owner_q == OWN_DMA) begin
            dma_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, command latches and read-data holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= 3'd0;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Outputs decode straight from state so a reset drops them immediately.
  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_ack   = (state_q == S_DONE) && (owner_q == OWN_CPU);
    dma_ack   = (state_q == S_DONE) && (owner_q == OWN_DMA);
    cpu_rdata = cpu_rdata_q;
    dma_rdata = dma_rdata_q;
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances run side by side, one with
// MEM_LAT=1 and one with MEM_LAT=3, each with its own memory, requesters and a
// transaction-level reference model that predicts every output on every cycle.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock / shared bookkeeping
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input int inst, input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL lat%0d %s: got 0x%0h, expected 0x%0h", inst, nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_ack, dma_ack, mem_en, mem_we, busy;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    state_dbg;
    logic          done;
    logic          chk_en;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
    );

    // Memory environment: data valid exactly LAT cycles after mem_en, noise otherwise.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] pipe_d [LAT];
    logic        pipe_v [LAT];
    logic [31:0] junk;

    function automatic logic [31:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
      junk <= $urandom;
      if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
      pipe_v[0] <= mem_en && !mem_we;
      pipe_d[0] <= env_rd(mem_addr);
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

    // Reference model: per-access schedule (issue cycle, ack cycle) and a shadow memory.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_busy, m_owner, m_we, m_last;
    int          m_issue, m_ack;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] exp_rd [2];
    int          cyc = 0;

    always @(negedge clk) begin
      logic e_en, e_we, e_ca, e_da, e_busy;
      bit   w;
      e_en = 0; e_we = 0; e_ca = 0; e_da = 0; e_busy = 0; w = 0;
      cyc++;
      if (chk_en) begin
        if (rst) begin
          m_busy = 0; m_last = 1; m_owner = 0; m_we = 0;
          m_addr = 0; m_wdata = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        end else if (m_busy) begin
          e_busy = 1;
          e_en   = (cyc == m_issue);
          e_we   = e_en && m_we;
          if (cyc == m_ack) begin
            if (!m_we) exp_rd[m_owner] = m_rd;
            e_ca = !m_owner;
            e_da = m_owner;
          end
        end
        check(LAT, "mem_en", mem_en, e_en);
        check(LAT, "mem_we", mem_we, e_we);
        check(LAT, "cpu_ack", cpu_ack, e_ca);
        check(LAT, "dma_ack", dma_ack, e_da);
        check(LAT, "busy", busy, e_busy);
        check(LAT, "mem_addr", mem_addr, m_addr);
        check(LAT, "mem_wdata", mem_wdata, m_wdata);
        check(LAT, "cpu_rdata", cpu_rdata, exp_rd[0]);
        check(LAT, "dma_rdata", dma_rdata, exp_rd[1]);
        if (!rst) begin
          if (m_busy && cyc == m_ack) begin
            m_busy = 0;
          end else if (!m_busy && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
            w = !cpu_req;
`else
            w = (cpu_req && dma_req) ? !m_last : dma_req;
`endif
            m_owner = w;
            m_last  = w;
            m_we    = w ? dma_we : cpu_we;
            m_addr  = w ? dma_addr : cpu_addr;
            m_wdata = w ? dma_wdata : cpu_wdata;
            m_issue = cyc + 1;
            m_ack   = cyc + 2 + (m_we ? 0 : LAT);
            m_busy  = 1;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else m_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
          end
        end
      end
    end

    // Driver tasks
    task automatic run_one(input bit dma, input bit we, input logic [31:0] a,
                           input logic [31:0] d, output int en_c, output int ack_c,
                           output int b_first, output int b_n, output bit oth,
                           output bit we_at_en);
      en_c = -1; ack_c = -1; b_first = -1; b_n = 0; oth = 0; we_at_en = 0;
      @(posedge clk); #1;
      if (dma) begin
        dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
      end else begin
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (mem_en && en_c < 0) begin
          en_c = k;
          we_at_en = mem_we;
        end
        if (busy) begin
          b_n++;
          if (b_first < 0) b_first = k;
        end
        if (dma ? cpu_ack : dma_ack) oth = 1;
        if (dma ? dma_ack : cpu_ack) begin
          ack_c = k;
          break;
        end
      end
      @(posedge clk); #1;
      cpu_req = 0;
      dma_req = 0;
    endtask

    task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1; cpu_req = 0; dma_req = 0;
      @(posedge clk); #1;
      rst = 0;
    endtask

    task automatic drv(input bit dma, input int n);
      bit got;
      for (int t = 0; t < n; t++) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        if (dma) begin
          dma_req = 1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = $urandom_range(0, 63); dma_wdata = $urandom;
        end else begin
          cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = $urandom_range(0, 63); cpu_wdata = $urandom;
        end
        got = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (dma ? dma_ack : cpu_ack) begin
            got = 1;
            break;
          end
        end
        check(LAT, dma ? "dma_ack_timeout" : "cpu_ack_timeout", got, 1);
        @(posedge clk); #1;
        if (dma) dma_req = 0;
        else cpu_req = 0;
      end
    endtask

    // Directed scenarios, then randomized traffic from both requesters.
    initial begin
      int en_c, ack_c, bf, bn, na, first_own;
      bit oth, wen, seen;
      int own [4];
      int exp_own [4];
      done = 0; chk_en = 0; rst = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      #2 rst = 1;
      chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check(LAT, "rst_busy", busy, 0);
      check(LAT, "rst_mem_en", mem_en, 0);
      check(LAT, "rst_state", state_dbg, 0);
      check(LAT, "rst_cpu_rdata", cpu_rdata, 0);
      @(posedge clk); #1;
      rst = 0;

      // CPU read of 0x10
      run_one(0, 0, 32'h10, 32'h0, en_c, ack_c, bf, bn, oth, wen);
      check(LAT, "rd_en_cycle", en_c, 1);
      check(LAT, "rd_ack_cycle", ack_c, 2 + LAT);
      check(LAT, "rd_busy_first", bf, 1);
      check(LAT, "rd_busy_cycles", bn, 2 + LAT);
      check(LAT, "rd_no_dma_ack", oth, 0);
      check(LAT, "rd_data_held", cpu_rdata, 32'hDEADBEEF);

      // DMA write of 0x1234 to 0x20
      run_one(1, 1, 32'h20, 32'h00001234, en_c, ack_c, bf, bn, oth, wen);
      check(LAT, "wr_en_cycle", en_c, 1);
      check(LAT, "wr_mem_we", wen, 1);
      check(LAT, "wr_ack_cycle", ack_c, 2);
      check(LAT, "wr_mem_value", env_rd(32'h20), 32'h00001234);
      check(LAT, "wr_dma_rdata", dma_rdata, 0);

      // Both requests held from reset
      pulse_reset();
`ifdef MEM_ARB_CPU_PRIORITY_EN
      exp_own = '{0, 0, 0, 0};
`else
      exp_own = '{0, 1, 0, 1};
`endif
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = $urandom;
      dma_req = 1; dma_we = 1; dma_addr = 32'h31; dma_wdata = $urandom;
      na = 0;
      for (int k = 0; k < 100 && na < 4; k++) begin
        @(negedge clk);
        if (cpu_ack) begin own[na] = 0; na++; end
        else if (dma_ack) begin own[na] = 1; na++; end
      end
      @(posedge clk); #1;
      cpu_req = 0; dma_req = 0;
      check(LAT, "tie_grants", na, 4);
      for (int i = 0; i < 4; i++) check(LAT, $sformatf("tie_owner%0d", i), own[i], exp_own[i]);

      // Reset during WAIT of a CPU read
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      repeat (2) @(posedge clk);
      #1;
      check(LAT, "abort_in_wait", busy, 1);
      rst = 1;
      #1;
      check(LAT, "abort_busy", busy, 0);
      check(LAT, "abort_state", state_dbg, 0);
      check(LAT, "abort_cpu_ack", cpu_ack, 0);
      check(LAT, "abort_mem_addr", mem_addr, 0);
      @(posedge clk); #1;
      rst = 0; cpu_req = 0;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (cpu_ack || dma_ack) seen = 1;
      end
      check(LAT, "abort_no_ack", seen, 0);
      @(posedge clk); #1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h3A; cpu_wdata = $urandom;
      dma_req = 1; dma_we = 1; dma_addr = 32'h3B; dma_wdata = $urandom;
      first_own = -1;
      for (int k = 0; k < 40 && first_own < 0; k++) begin
        @(negedge clk);
        if (cpu_ack) first_own = 0;
        else if (dma_ack) first_own = 1;
      end
      @(posedge clk); #1;
      cpu_req = 0; dma_req = 0;
      check(LAT, "post_reset_owner", first_own, 0);

      // Randomized traffic
      fork
        drv(0, 60);
        drv(1, 60);
      join
      repeat (5) @(posedge clk);
      done = 1;
    end
  end

  // Final report
  initial begin
    for (int t = 0; t < 50000 && !(g[0].done && g[1].done); t++) @(posedge clk);
    check(0, "all_done", {g[0].done, g[1].done}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
